// File: rtl/timer_bus_master.sv
// timer_bus_master: turns READ_TIME / WRITE_CMP / WRITE_MSIP commands into 32-bit
// timer-block bus accesses, with a tear-free MTIME read and a glitch-free MTIMECMP update.
module timer_bus_master #(
  parameter logic [31:0] BASE      = 32'h1100_0000,
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);

  localparam int WCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int RCW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MSIP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [31:0] OFF_MSIP    = 32'h0000_0000;
  localparam logic [31:0] OFF_CMP_L   = 32'h0000_4000;
  localparam logic [31:0] OFF_CMP_H   = 32'h0000_4004;
  localparam logic [31:0] OFF_MTIME_L = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MTIME_H = 32'h0000_BFFC;

  typedef enum logic [2:0] {IDLE, REQ, GAP, CHECK, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [1:0]      op_q;
  logic [63:0]     data_q;
  logic [31:0]     h1_q, lo_q, h2_q;
  logic [RCW-1:0]  retry_q;
  logic [WCW-1:0]  wait_q;
  logic            start_access, finish, fin_err;
  logic [63:0]     fin_data;
  logic [1:0]      acc_op;
  logic [63:0]     acc_src;
  logic [31:0]     acc_addr, acc_wdata;
  logic [3:0]      acc_wmask;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    start_access = 1'b0;
    finish       = 1'b0;
    fin_err      = 1'b0;
    fin_data     = '0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        step_d = '0;
        if (cmd_op == OP_RSVD) begin
          state_d = RESP;
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          state_d      = REQ;
          start_access = 1'b1;
        end
      end
      // Ready wins over timeout when both land on the last wait cycle.
      REQ: if (ready) begin
        state_d = GAP;
      end else if (wait_q == WAIT_LAST) begin
        state_d = RESP;
        finish  = 1'b1;
        fin_err = 1'b1;
      end
      GAP: if (op_q == OP_READ && step_q == 2'd2) begin
        state_d = CHECK;
      end else if (op_q != OP_MSIP && step_q != 2'd2) begin
        state_d      = REQ;
        step_d       = step_q + 2'd1;
        start_access = 1'b1;
      end else begin
        state_d = RESP;
        finish  = 1'b1;
      end
      CHECK: if (h2_q == h1_q) begin
        state_d  = RESP;
        finish   = 1'b1;
        fin_data = {h1_q, lo_q};
      end else if (retry_q == RETRY_MAX) begin
        state_d = RESP;
        finish  = 1'b1;
        fin_err = 1'b1;
      end else begin
        state_d      = REQ;
        step_d       = 2'd1;
        start_access = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MTIMECMP low word is parked at all-ones first so the compare never dips low mid-update.
  always_comb begin
    acc_op    = (state_q == IDLE) ? cmd_op : op_q;
    acc_src   = (state_q == IDLE) ? cmd_wdata : data_q;
    acc_addr  = BASE + OFF_MTIME_H;
    acc_wmask = 4'h0;
    acc_wdata = '0;
    case (acc_op)
      OP_READ: if (step_d == 2'd1) acc_addr = BASE + OFF_MTIME_L;
      OP_CMP: begin
        acc_wmask = 4'hF;
        case (step_d)
          2'd0: begin
            acc_addr  = BASE + OFF_CMP_L;
            acc_wdata = 32'hFFFF_FFFF;
          end
          2'd1: begin
            acc_addr  = BASE + OFF_CMP_H;
            acc_wdata = acc_src[63:32];
          end
          default: begin
            acc_addr  = BASE + OFF_CMP_L;
            acc_wdata = acc_src[31:0];
          end
        endcase
      end
      OP_MSIP: begin
        acc_addr  = BASE + OFF_MSIP;
        acc_wmask = 4'hF;
        acc_wdata = {31'b0, acc_src[0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q   <= '0;
      op_q     <= '0;
      data_q   <= '0;
      h1_q     <= '0;
      lo_q     <= '0;
      h2_q     <= '0;
      retry_q  <= '0;
      wait_q   <= '0;
      valid    <= 1'b0;
      addr     <= '0;
      wmask    <= '0;
      wdata    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      step_q <= step_d;
      if (state_q == IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        data_q  <= cmd_wdata;
        retry_q <= '0;
      end
      if (start_access) begin
        valid  <= 1'b1;
        addr   <= acc_addr;
        wmask  <= acc_wmask;
        wdata  <= acc_wdata;
        wait_q <= '0;
      end else if (state_q == REQ) begin
        if (state_d != REQ) valid <= 1'b0;
        else                wait_q <= wait_q + 1'b1;
      end
      if (state_q == REQ && ready) begin
        case (step_q)
          2'd0:    h1_q <= rdata;
          2'd1:    lo_q <= rdata;
          default: h2_q <= rdata;
        endcase
      end
      if (state_q == CHECK && state_d == REQ) begin
        h1_q    <= h2_q;
        retry_q <= retry_q + 1'b1;
      end
      if (finish) begin
        rsp_data <= fin_data;
        rsp_err  <= fin_err;
      end else if (state_q == RESP) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_bus_master.sv
// tb_timer_bus_master: directed bench with a registered-ready timer responder model
// that can roll MTIME, withhold ready, or delay it to the timeout boundary.
module tb_timer_bus_master;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready = 1'b0;

  int nvec = 0;
  int nerr = 0;

  timer_bus_master #(.BASE(BASE), .TIMEOUT(255), .MAX_RETRY(3)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .valid(valid), .addr(addr), .wmask(wmask), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  // Responder model: roll_mode 0 = stable MTIME, 1 = one carry into the high word after the
  // first MTIME_H read, 2 = high word increments after every MTIME_H read.
  logic [63:0] mtime_base = 64'h0;
  int          roll_mode = 0;
  int          hr0 = 0;
  int          h_reads = 0;
  int          hdelta;
  logic [63:0] mtime;
  logic [63:0] mtimecmp = '1;
  logic [31:0] msip = '0;
  bit          ready_en = 1'b1;
  int          ready_delay = 1;
  int          vcnt = 0;
  int          irq_count = 0;
  int          rsp_count = 0;
  int          valid_count = 0;
  logic [31:0] acc_addr_q[$];
  logic [31:0] acc_wdata_q[$];
  logic [3:0]  acc_wmask_q[$];

  assign hdelta = h_reads - hr0;

  always_comb begin
    case (roll_mode)
      1:       mtime = (hdelta >= 1) ? 64'h0000_0001_0000_0000 : mtime_base;
      2:       mtime = mtime_base + {32'(hdelta), 32'h0};
      default: mtime = mtime_base;
    endcase
  end

  always_comb begin
    case (addr - BASE)
      32'h0000_0000: rdata = msip;
      32'h0000_4000: rdata = mtimecmp[31:0];
      32'h0000_4004: rdata = mtimecmp[63:32];
      32'h0000_BFF8: rdata = mtime[31:0];
      32'h0000_BFFC: rdata = mtime[63:32];
      default:       rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    ready <= valid && ready_en && (vcnt + 1 >= ready_delay);
    vcnt  <= valid ? vcnt + 1 : 0;
    if (valid && ready) begin
      acc_addr_q.push_back(addr);
      acc_wdata_q.push_back(wdata);
      acc_wmask_q.push_back(wmask);
      if (wmask == 4'hF) begin
        case (addr - BASE)
          32'h0000_0000: msip <= wdata;
          32'h0000_4000: mtimecmp[31:0] <= wdata;
          32'h0000_4004: mtimecmp[63:32] <= wdata;
          default: ;
        endcase
      end else if (addr == BASE + 32'h0000_BFFC) begin
        h_reads <= h_reads + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mtime >= mtimecmp) irq_count <= irq_count + 1;
    if (rsp_valid) rsp_count <= rsp_count + 1;
    if (valid) valid_count <= valid_count + 1;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one command and returns edges from acceptance until rsp_valid is seen.
  task automatic apply_stimulus(input logic [1:0] op, input logic [63:0] data,
                                output int lat, output logic [63:0] got_data, output logic got_err);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got_data = rsp_data;
    got_err  = rsp_err;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, a0, i0, r0, v0, n;
    logic [63:0] d;
    logic        e;

    resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check_output("reset_cmd_ready", 64'(cmd_ready), 64'h1);
    check_output("reset_valid", 64'(valid), 64'h0);
    check_output("reset_addr", 64'(addr), 64'h0);
    check_output("reset_wmask", 64'(wmask), 64'h0);
    check_output("reset_wdata", 64'(wdata), 64'h0);
    check_output("reset_rsp", {rsp_data[62:0], rsp_valid | rsp_err | rsp_data[63]}, 64'h0);
    resetn = 1'b1;
    $display("[TB] reset released");

    mtime_base = 64'h0000_0002_1234_5678;
    a0 = acc_addr_q.size();
    apply_stimulus(2'b00, 64'h0, lat, d, e);
    check_output("read_stable_data", d, 64'h0000_0002_1234_5678);
    check_output("read_stable_err", 64'(e), 64'h0);
    check_output("read_stable_count", 64'(acc_addr_q.size() - a0), 64'd3);
    check_output("read_stable_a0", 64'(acc_addr_q[a0]), 64'h1100_BFFC);
    check_output("read_stable_a1", 64'(acc_addr_q[a0+1]), 64'h1100_BFF8);
    check_output("read_stable_a2", 64'(acc_addr_q[a0+2]), 64'h1100_BFFC);
    check_output("read_stable_wmask", 64'(acc_wmask_q[a0]), 64'h0);

    mtime_base = 64'h0000_0000_FFFF_FFFF;
    hr0 = h_reads;
    roll_mode = 1;
    a0 = acc_addr_q.size();
    apply_stimulus(2'b00, 64'h0, lat, d, e);
    check_output("read_roll_data", d, 64'h0000_0001_0000_0000);
    check_output("read_roll_err", 64'(e), 64'h0);
    check_output("read_roll_count", 64'(acc_addr_q.size() - a0), 64'd5);

    mtime_base = 64'h0000_0005_0000_0000;
    hr0 = h_reads;
    roll_mode = 2;
    a0 = acc_addr_q.size();
    apply_stimulus(2'b00, 64'h0, lat, d, e);
    check_output("read_exhaust_err", 64'(e), 64'h1);
    check_output("read_exhaust_data", d, 64'h0);
    check_output("read_exhaust_count", 64'(acc_addr_q.size() - a0), 64'd9);
    roll_mode = 0;

    mtime_base = 64'h0000_0002_1234_5678;
    a0 = acc_addr_q.size();
    i0 = irq_count;
    apply_stimulus(2'b01, 64'h0000_0003_0000_0010, lat, d, e);
    check_output("cmp_err", 64'(e), 64'h0);
    check_output("cmp_data", d, 64'h0);
    check_output("cmp_count", 64'(acc_addr_q.size() - a0), 64'd3);
    check_output("cmp_w0", {acc_addr_q[a0], acc_wdata_q[a0]}, 64'h1100_4000_FFFF_FFFF);
    check_output("cmp_w1", {acc_addr_q[a0+1], acc_wdata_q[a0+1]}, 64'h1100_4004_0000_0003);
    check_output("cmp_w2", {acc_addr_q[a0+2], acc_wdata_q[a0+2]}, 64'h1100_4000_0000_0010);
    check_output("cmp_wmask", 64'({acc_wmask_q[a0], acc_wmask_q[a0+1], acc_wmask_q[a0+2]}), 64'hFFF);
    check_output("cmp_value", mtimecmp, 64'h0000_0003_0000_0010);
    check_output("cmp_no_irq", 64'(irq_count - i0), 64'h0);

    apply_stimulus(2'b10, 64'h1, lat, d, e);
    check_output("msip_latency", 64'(lat), 64'd3);
    check_output("msip_err", 64'(e), 64'h0);
    check_output("msip_value", 64'(msip), 64'h1);
    @(posedge clk);
    #1;
    check_output("msip_cmd_ready_after", 64'({cmd_ready, rsp_valid}), 64'b10);

    a0 = acc_addr_q.size();
    v0 = valid_count;
    apply_stimulus(2'b11, 64'h0, lat, d, e);
    check_output("rsvd_latency", 64'(lat), 64'd0);
    check_output("rsvd_err", 64'(e), 64'h1);
    check_output("rsvd_data", d, 64'h0);
    check_output("rsvd_no_bus", 64'(valid_count - v0), 64'h0);

    ready_en = 1'b0;
    apply_stimulus(2'b10, 64'h0, lat, d, e);
    check_output("timeout_latency", 64'(lat), 64'd255);
    check_output("timeout_err", 64'(e), 64'h1);
    check_output("timeout_data", d, 64'h0);
    check_output("timeout_valid_low", 64'(valid), 64'h0);
    check_output("timeout_msip_kept", 64'(msip), 64'h1);
    ready_en = 1'b1;

    ready_delay = 254;
    apply_stimulus(2'b10, 64'h0, lat, d, e);
    check_output("edge_timeout_latency", 64'(lat), 64'd256);
    check_output("edge_timeout_err", 64'(e), 64'h0);
    check_output("edge_timeout_msip", 64'(msip), 64'h0);
    ready_delay = 1;

    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    a0 = acc_addr_q.size();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_wdata = 64'h0000_0007_0000_0020;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(acc_addr_q.size() == a0 + 1 && valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_mid_second_access", 64'(valid), 64'h1);
    r0 = rsp_count;
    #2;
    resetn = 1'b0;
    #1;
    check_output("rst_mid_valid_async", 64'({valid, wmask, rsp_valid}), 64'h0);
    check_output("rst_mid_cmp_partial", mtimecmp, 64'h0000_0003_FFFF_FFFF);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_output("rst_mid_no_rsp", 64'(rsp_count - r0), 64'h0);
    check_output("rst_mid_cmd_ready", 64'(cmd_ready), 64'h1);
    apply_stimulus(2'b10, 64'h1, lat, d, e);
    check_output("rst_after_latency", 64'(lat), 64'd3);
    check_output("rst_after_err", 64'(e), 64'h0);
    check_output("rst_after_msip", 64'(msip), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
